// File: rtl/scc68070_irq_ctrl.sv
// SCC68070 interrupt arbiter: level registers, IPL encoder and interrupt-acknowledge vector FSM.
// Optional MASK register is enabled by defining SCC_IRQ_MASK_EN.
//
// state | meaning
// IDLE  | waiting for iack_req
// SNAP  | pick the source at iack_level, latch vector
// ACK   | iack_ack pulse, clears a selected INT1/INT2 latch
// REL   | waiting for iack_req to drop
module scc68070_irq_ctrl #(
  parameter logic [7:0] ONCHIP_VEC_BASE = 8'h38,
  parameter logic [7:0] SPURIOUS_VEC    = 8'h18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in2,
  input  logic       in4,
  input  logic       in5,
  input  logic       int1,
  input  logic       int2,
  input  logic       timer_irq,
  input  logic       i2c_irq,
  input  logic       urx_irq,
  input  logic       utx_irq,
  input  logic       reg_wr,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic [2:0] ipl,
  input  logic       iack_req,
  input  logic [2:0] iack_level,
  output logic       iack_ack,
  output logic [7:0] iack_vector,
  output logic       iack_auto
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SNAP = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  localparam int SRC_N = 9;

  logic [2:0] r_int1_lvl, r_int2_lvl, r_timer_lvl, r_i2c_lvl, r_urx_lvl, r_utx_lvl;
  logic       r_int1_prev, r_int2_prev;
  logic       r_int1_lat, r_int2_lat;
  logic [1:0] r_state;
  logic [2:0] r_ipl;
  logic       r_ack;
  logic [7:0] r_vector;
  logic       r_auto;
  logic       r_sel_int1, r_sel_int2;

  logic [5:0] w_mask;
  logic [8:0] w_req;
  logic [2:0] w_lvl [SRC_N];
  logic [2:0] w_win;
  logic       w_hit;
  logic [3:0] w_hit_idx;
  logic [7:0] w_vec;
  logic       w_auto;
  logic       w_set1, w_set2, w_clr1, w_clr2;
  logic       w_unused_wdata;

  assign w_unused_wdata = ^{reg_wdata[7], reg_wdata[3]};

`ifdef SCC_IRQ_MASK_EN
  logic [5:0] r_mask;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= 6'h3F;
    end else if (reg_wr && (reg_sel == 2'd3)) begin
      r_mask <= reg_wdata[5:0];
    end
  end
  assign w_mask = r_mask;
`else
  assign w_mask = 6'h3F;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_int1_lvl  <= 3'd0;
      r_int2_lvl  <= 3'd0;
      r_timer_lvl <= 3'd0;
      r_i2c_lvl   <= 3'd0;
      r_urx_lvl   <= 3'd0;
      r_utx_lvl   <= 3'd0;
    end else if (reg_wr) begin
      case (reg_sel)
        2'd0: begin
          r_int1_lvl <= reg_wdata[6:4];
          r_int2_lvl <= reg_wdata[2:0];
        end
        2'd1: begin
          r_i2c_lvl   <= reg_wdata[6:4];
          r_timer_lvl <= reg_wdata[2:0];
        end
        2'd2: begin
          r_urx_lvl <= reg_wdata[6:4];
          r_utx_lvl <= reg_wdata[2:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (reg_sel)
      2'd0:    reg_rdata = {1'b0, r_int1_lvl, 1'b0, r_int2_lvl};
      2'd1:    reg_rdata = {1'b0, r_i2c_lvl, 1'b0, r_timer_lvl};
      2'd2:    reg_rdata = {1'b0, r_urx_lvl, 1'b0, r_utx_lvl};
      default: reg_rdata = {2'b00, w_mask};
    endcase
  end

  // Index order is the tie-break order, index 0 wins
  assign w_req = {in2, in4, in5,
                  utx_irq & w_mask[0], urx_irq & w_mask[1], i2c_irq & w_mask[2],
                  timer_irq & w_mask[3], r_int2_lat & w_mask[4], r_int1_lat & w_mask[5]};
  assign w_lvl[0] = r_int1_lvl;
  assign w_lvl[1] = r_int2_lvl;
  assign w_lvl[2] = r_timer_lvl;
  assign w_lvl[3] = r_i2c_lvl;
  assign w_lvl[4] = r_urx_lvl;
  assign w_lvl[5] = r_utx_lvl;
  assign w_lvl[6] = 3'd5;
  assign w_lvl[7] = 3'd4;
  assign w_lvl[8] = 3'd2;

  always_comb begin
    w_win     = 3'd0;
    w_hit     = 1'b0;
    w_hit_idx = 4'd0;
    for (int i = SRC_N - 1; i >= 0; i--) begin
      if (w_req[i] && (w_lvl[i] != 3'd0)) begin
        if (w_lvl[i] > w_win) w_win = w_lvl[i];
        if (w_lvl[i] == iack_level) begin
          w_hit     = 1'b1;
          w_hit_idx = 4'(i);
        end
      end
    end
  end

  always_comb begin
    w_vec  = SPURIOUS_VEC;
    w_auto = 1'b0;
    if (w_hit) begin
      if (w_hit_idx >= 4'd6) begin
        w_vec  = 8'h18 + {5'd0, iack_level};
        w_auto = 1'b1;
      end else begin
        w_vec  = ONCHIP_VEC_BASE + {5'd0, iack_level};
      end
    end
  end

  // A new edge in the clearing cycle keeps the latch set
  assign w_set1 = int1 & ~r_int1_prev & w_mask[5];
  assign w_set2 = int2 & ~r_int2_prev & w_mask[4];
  assign w_clr1 = (r_state == ST_ACK) & r_sel_int1;
  assign w_clr2 = (r_state == ST_ACK) & r_sel_int2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_int1_prev <= 1'b0;
      r_int2_prev <= 1'b0;
      r_int1_lat  <= 1'b0;
      r_int2_lat  <= 1'b0;
      r_ipl       <= 3'd0;
    end else begin
      r_int1_prev <= int1;
      r_int2_prev <= int2;
      r_int1_lat  <= w_set1 | (r_int1_lat & ~w_clr1);
      r_int2_lat  <= w_set2 | (r_int2_lat & ~w_clr2);
      r_ipl       <= w_win;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_ack      <= 1'b0;
      r_vector   <= 8'd0;
      r_auto     <= 1'b0;
      r_sel_int1 <= 1'b0;
      r_sel_int2 <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: if (iack_req) r_state <= ST_SNAP;
        ST_SNAP: begin
          r_state    <= ST_ACK;
          r_ack      <= 1'b1;
          r_vector   <= w_vec;
          r_auto     <= w_auto;
          r_sel_int1 <= w_hit && (w_hit_idx == 4'd0);
          r_sel_int2 <= w_hit && (w_hit_idx == 4'd1);
        end
        ST_ACK:  r_state <= ST_REL;
        ST_REL:  if (!iack_req) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ipl         = r_ipl;
  assign iack_ack    = r_ack;
  assign iack_vector = r_vector;
  assign iack_auto   = r_auto;

endmodule
